// File: rtl/digital_fll_ctrl_param.sv
// Frequency-lock controller: counts ring-oscillator cycles per reference period and servoes a
// thermometer trim code. Define DIGITAL_FLL_MANUAL_TRIM_EN to add the manual trim override ports.
module digital_fll_ctrl_param #(
  parameter int TRIM_W    = 26,
  parameter int DIV_W     = 5,
  parameter int CNT_W     = 8,
  parameter int TOL       = 1,
  parameter int LOCK_CNT  = 4,
  parameter int TRIM_INIT = 13
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic                          enable,
  input  logic                          osc,
  input  logic [DIV_W-1:0]              div,
`ifdef DIGITAL_FLL_MANUAL_TRIM_EN
  input  logic                          ext_trim_sel,
  input  logic [$clog2(TRIM_W+1)-1:0]   ext_trim_code,
`endif
  output logic [TRIM_W-1:0]             trim,
  output logic [$clog2(TRIM_W+1)-1:0]   trim_code,
  output logic                          locked,
  output logic                          ref_lost
);

  localparam int CODE_W = $clog2(TRIM_W + 1);
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MW     = CNT_W + 1;

  localparam logic [CODE_W-1:0] CODE_MAX  = CODE_W'(TRIM_W);
  localparam logic [CODE_W-1:0] CODE_INIT = CODE_W'(TRIM_INIT);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_CNT);
  localparam logic [MW-1:0]     TOL_M     = MW'(TOL);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  function automatic logic [CODE_W-1:0] code_up(input logic [CODE_W-1:0] c);
    return (c >= CODE_MAX) ? CODE_MAX : c + CODE_W'(1);
  endfunction

  function automatic logic [CODE_W-1:0] code_dn(input logic [CODE_W-1:0] c);
    return (c == '0) ? '0 : c - CODE_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] run_up(input logic [RUN_W-1:0] r);
    return (r >= RUN_MAX) ? RUN_MAX : r + RUN_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_up(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
  endfunction

  logic              osc_p0, osc_p1, osc_p2;
  logic              vld_p3;
  logic [CNT_W-1:0]  count_q;
  logic [CODE_W-1:0] code_q;
  logic [RUN_W-1:0]  run_q;
  logic              locked_q, lost_q, first_q;

  logic              force_sel;
  logic [CODE_W-1:0] force_code;

`ifdef DIGITAL_FLL_MANUAL_TRIM_EN
  assign force_sel  = ext_trim_sel;
  assign force_code = (ext_trim_code > CODE_MAX) ? CODE_MAX : ext_trim_code;
`else
  assign force_sel  = 1'b0;
  assign force_code = CODE_INIT;
`endif

  // Window compare one bit wider than the counter so div+TOL cannot wrap
  logic [MW-1:0] m_ext, div_ext, win_hi, win_lo;
  logic          too_fast, too_slow;

  always_comb begin
    m_ext    = {1'b0, count_q};
    div_ext  = MW'(div);
    win_hi   = div_ext + TOL_M;
    win_lo   = (div_ext > TOL_M) ? div_ext - TOL_M : '0;
    too_fast = (m_ext > win_hi);
    too_slow = (m_ext < win_lo);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      osc_p0   <= 1'b0;
      osc_p1   <= 1'b0;
      osc_p2   <= 1'b0;
      vld_p3   <= 1'b0;
      count_q  <= '0;
      code_q   <= CODE_INIT;
      run_q    <= '0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      first_q  <= 1'b1;
    end else if (!enable) begin
      osc_p0   <= 1'b0;
      osc_p1   <= 1'b0;
      osc_p2   <= 1'b0;
      vld_p3   <= 1'b0;
      count_q  <= '0;
      code_q   <= CODE_INIT;
      run_q    <= '0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      first_q  <= 1'b1;
    end else begin
      // p0/p1: synchroniser, p2: previous level, p3: registered rising-edge event
      osc_p0  <= osc;
      osc_p1  <= osc_p0;
      osc_p2  <= osc_p1;
      vld_p3  <= osc_p1 & ~osc_p2;
      count_q <= vld_p3 ? CNT_W'(1) : cnt_up(count_q);

      if (force_sel) begin
        code_q   <= force_code;
        run_q    <= '0;
        locked_q <= 1'b0;
        first_q  <= 1'b1;
      end else if (vld_p3) begin
        if (div == '0) begin
          run_q    <= '0;
          locked_q <= 1'b0;
          lost_q   <= 1'b0;
        end else if (first_q || count_q == CNT_MAX) begin
          // Measurement spans a restart or a lost reference: not trustworthy
          first_q <= 1'b0;
          lost_q  <= 1'b0;
        end else if (too_fast) begin
          code_q   <= code_up(code_q);
          run_q    <= '0;
          locked_q <= 1'b0;
        end else if (too_slow) begin
          code_q   <= code_dn(code_q);
          run_q    <= '0;
          locked_q <= 1'b0;
        end else begin
          run_q <= run_up(run_q);
          if (run_up(run_q) == RUN_MAX) locked_q <= 1'b1;
        end
      end else if (count_q == CNT_MAX) begin
        lost_q   <= 1'b1;
        locked_q <= 1'b0;
        run_q    <= '0;
        first_q  <= 1'b1;
      end else if (div == '0) begin
        run_q    <= '0;
        locked_q <= 1'b0;
      end
    end
  end

  always_comb begin
    trim = '0;
    for (int i = 0; i < TRIM_W; i++) trim[i] = (CODE_W'(i) < code_q);
  end

  assign trim_code = code_q;
  assign locked    = locked_q;
  assign ref_lost  = lost_q;

endmodule
